// File: rtl/memory_responder.sv
// Word-addressed RAM answering datapath memory requests over a read/write/done handshake.
// Latency WAIT_CYCLES+1 edges from request sample to done; done held until the request drops.
module memory_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] mdatain,
    output logic                  done,
    output logic                  err
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic                    op_wr;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

`ifndef SYNTHESIS
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
`endif

    // The access happens on the edge that leaves ACCESS; an async clear before it cancels it.
    assign commit = (state == ACCESS) && (cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (read ^ write)    state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0)     state_nxt = DONE;
            DONE:    if (!(read | write)) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mdatain <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (read ^ write) begin
                        op_wr  <= write;
                        addr_q <= address;
                        data_q <= data_in;
                        cnt    <= WAIT_LOAD;
                    end else if (read & write) begin
                        err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!op_wr) mdatain <= mem[addr_q];
                        done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!(read | write)) done <= 1'b0;
                end
                default: done <= 1'b0;
            endcase
        end
    end

    // No reset on the array: its contents survive clear.
    always @(posedge clock) begin
        if (commit && op_wr) mem[addr_q] <= data_q;
    end
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances with WAIT_CYCLES 1, 2 and 3.
module tb_memory_responder;
    typedef struct {
        logic        is_err;
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic [2:0]  clr;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [8:0]  addr [3];
    logic [31:0] din  [3];
    logic [31:0] mdo  [3];

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    logic done_q = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        memory_responder #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (9),
            .WAIT_CYCLES(g + 1)
        ) u_dut (
            .clock  (clk),
            .clear  (clr[g]),
            .read   (rd[g]),
            .write  (wr[g]),
            .address(addr[g]),
            .data_in(din[g]),
            .mdatain(mdo[g]),
            .done   (done[g]),
            .err    (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Instance 0 monitor: every done rise or err pulse consumes one expected event.
    always @(negedge clk) begin
        if (!clr[0]) begin
            if (done[0] && !done_q) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_done_kind", {31'd0, e.is_err}, 32'd0);
                    if (e.is_read) chk("sb_rdata", mdo[0], e.data);
                end
            end
            if (err[0]) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_err", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_err_kind", {31'd0, e.is_err}, 32'd1);
                end
            end
        end
        done_q <= done[0];
    end

    // Full handshake on instance i; for reads on instance 0, d is the expected data.
    task automatic do_acc(input int i, input bit w, input logic [8:0] a, input logic [31:0] d);
        int k;
        if (i == 0) q.push_back('{is_err: 1'b0, is_read: !w, data: d});
        @(negedge clk);
        rd[i] = !w; wr[i] = w; addr[i] = a; din[i] = w ? d : 32'h0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done[i]) break;
        end
        chk("latency", k, i + 2);
        rd[i] = 1'b0; wr[i] = 1'b0;
        @(negedge clk);
        chk("done_fall", {31'd0, done[i]}, 32'd0);
    endtask

    initial begin
        clr = 3'b111; rd = 3'b000; wr = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; din[i] = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_done", {31'd0, done[i]}, 32'd0);
            chk("rst_err", {31'd0, err[i]}, 32'd0);
            chk("rst_mdatain", mdo[i], 32'd0);
        end
        @(negedge clk);
        clr = 3'b000;

        // Write then read back on WAIT_CYCLES=1
        do_acc(0, 1'b1, 9'h005, 32'hDEADBEEF);
        do_acc(0, 1'b0, 9'h005, 32'hDEADBEEF);

        // WAIT_CYCLES=2 timing: request sampled at edge N
        @(negedge clk);
        rd[1] = 1'b1; addr[1] = 9'h033;
        @(negedge clk);
        chk("w2_done_after_N", {31'd0, done[1]}, 32'd0);
        @(negedge clk);
        chk("w2_done_after_N1", {31'd0, done[1]}, 32'd0);
        @(negedge clk);
        chk("w2_done_after_N2", {31'd0, done[1]}, 32'd0);
        @(negedge clk);
        chk("w2_done_after_N3", {31'd0, done[1]}, 32'd1);
        chk("w2_rdata_zero", mdo[1], 32'd0);
        rd[1] = 1'b0;
        @(negedge clk);
        chk("w2_done_fall", {31'd0, done[1]}, 32'd0);

        // read and write together for two edges
        q.push_back('{is_err: 1'b1, is_read: 1'b0, data: 32'h0});
        q.push_back('{is_err: 1'b1, is_read: 1'b0, data: 32'h0});
        @(negedge clk);
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 9'h010; din[0] = 32'h1;
        repeat (2) begin
            @(negedge clk);
            chk("both_err", {31'd0, err[0]}, 32'd1);
            chk("both_no_done", {31'd0, done[0]}, 32'd0);
        end
        rd[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        chk("both_err_end", {31'd0, err[0]}, 32'd0);
        chk("both_mdatain_held", mdo[0], 32'hDEADBEEF);
        do_acc(0, 1'b0, 9'h010, 32'h0);

        // Address extremes
        do_acc(0, 1'b1, 9'h1FF, 32'hA5A5A5A5);
        do_acc(0, 1'b1, 9'h000, 32'h5A5A5A5A);
        do_acc(0, 1'b0, 9'h1FF, 32'hA5A5A5A5);
        do_acc(0, 1'b0, 9'h000, 32'h5A5A5A5A);

        // Read held high after done
        q.push_back('{is_err: 1'b0, is_read: 1'b1, data: 32'hDEADBEEF});
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 9'h005;
        for (int k = 0; k < 20 && !done[0]; k++) @(negedge clk);
        chk("hold_done_rise", {31'd0, done[0]}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_done", {31'd0, done[0]}, 32'd1);
            chk("hold_mdatain", mdo[0], 32'hDEADBEEF);
        end
        rd[0] = 1'b0;
        @(negedge clk);
        chk("hold_done_fall", {31'd0, done[0]}, 32'd0);
        do_acc(0, 1'b0, 9'h005, 32'hDEADBEEF);

        // Clear during ACCESS on WAIT_CYCLES=3
        do_acc(2, 1'b1, 9'h020, 32'h11112222);
        do_acc(2, 1'b0, 9'h020, 32'h0);
        chk("clr_prior_read", mdo[2], 32'h11112222);
        @(negedge clk);
        wr[2] = 1'b1; addr[2] = 9'h020; din[2] = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        clr[2] = 1'b1;
        #1;
        chk("clr_done", {31'd0, done[2]}, 32'd0);
        chk("clr_mdatain", mdo[2], 32'd0);
        wr[2] = 1'b0;
        repeat (3) @(negedge clk);
        clr[2] = 1'b0;
        do_acc(2, 1'b0, 9'h020, 32'h0);
        chk("clr_array_kept", mdo[2], 32'h11112222);

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
